// File: rtl/fl_alloc_ctrl.sv
// fl_alloc_ctrl: rename-stage controller for the 2-wide physical-register freelist.
// Grants up to two PRs per cycle (all-or-nothing), queues commit frees in a small
// circular pending buffer drained two per cycle into registered push outputs, and
// runs a flush-drain phase that blocks rename until every pending free is returned.
// Optional feature macro: FL_STALL_CNT_EN adds the 16-bit saturating perf_stall_cnt port.
module fl_alloc_ctrl #(
    parameter int PR_W       = 6,
    parameter int PEND_DEPTH = 4
) (
    input  logic            clk,
    input  logic            reset,
    input  logic [1:0]      ren_valid,
    input  logic [1:0]      ren_need_pr,
    output logic            ren_ready,
    output logic [PR_W-1:0] alloc_pr0,
    output logic [PR_W-1:0] alloc_pr1,
    input  logic [1:0]      fr_valid,
    input  logic [PR_W-1:0] fr_pr0,
    input  logic [PR_W-1:0] fr_pr1,
    output logic            fr_ready,
    input  logic            flush,
    input  logic            no_free_pr,
    input  logic            one_free_pr,
    output logic [1:0]      pop_fl_RAT,
    input  logic [PR_W-1:0] pop_data_fl_RAT1,
    input  logic [PR_W-1:0] pop_data_fl_RAT2,
    output logic [1:0]      push_fl_RAT,
    output logic [PR_W-1:0] push_data_fl_RAT1,
    output logic [PR_W-1:0] push_data_fl_RAT2,
    output logic            drain_busy
`ifdef FL_STALL_CNT_EN
    ,
    output logic [15:0]     perf_stall_cnt
`endif
);

    localparam int PTR_W = (PEND_DEPTH > 1) ? $clog2(PEND_DEPTH) : 1;
    localparam int CNT_W = PTR_W + 1;
    localparam int SP_W  = CNT_W + 1;

    typedef enum logic {
        RUN   = 1'b0,
        DRAIN = 1'b1
    } state_t;

    state_t state;
    state_t state_nxt;

    logic            run_state;
    logic            n0;
    logic            n1;
    logic [1:0]      need;
    logic            avail;
    logic            grant;

    logic [PR_W-1:0] pend_mem [PEND_DEPTH];
    logic [PTR_W-1:0] rd_ptr;
    logic [PTR_W-1:0] wr_ptr;
    logic [CNT_W-1:0] count;
    logic            buf_empty;
    logic [1:0]      drain_cnt;
    logic [1:0]      enq_cnt;
    logic [PR_W-1:0] enq0;
    logic [PR_W-1:0] head0;
    logic [PR_W-1:0] head1;
    logic [SP_W-1:0] space;
    logic            drain_done;

    // Demand and availability of the rename group; grant is all-or-nothing.
    always_comb begin
        n0    = ren_valid[0] & ren_need_pr[0];
        n1    = ren_valid[1] & ren_need_pr[1];
        need  = {1'b0, n0} + {1'b0, n1};
        avail = 1'b0;
        case (need)
            2'd0:    avail = 1'b1;
            2'd1:    avail = ~no_free_pr;
            default: avail = ~no_free_pr & ~one_free_pr;
        endcase
        ren_ready  = reset & run_state & ~flush & avail;
        grant      = ren_ready & (ren_valid != 2'b00);
        pop_fl_RAT = grant ? need : 2'd0;
    end

    // Steer popped PRs to the needing slots in age order; idle slots read zero.
    always_comb begin
        alloc_pr0 = '0;
        alloc_pr1 = '0;
        if (grant) begin
            if (n0) begin
                alloc_pr0 = pop_data_fl_RAT1;
            end
            if (n1) begin
                alloc_pr1 = n0 ? pop_data_fl_RAT2 : pop_data_fl_RAT1;
            end
        end
    end

    // Pending-buffer bookkeeping: head drain amount, compacted enqueue, free space.
    always_comb begin
        buf_empty  = (count == '0);
        drain_cnt  = (count >= CNT_W'(2)) ? 2'd2 : 2'(count);
        enq_cnt    = {1'b0, fr_valid[0]} + {1'b0, fr_valid[1]};
        enq0       = fr_valid[0] ? fr_pr0 : fr_pr1;
        head0      = pend_mem[rd_ptr];
        head1      = pend_mem[rd_ptr + PTR_W'(1)];
        space      = SP_W'(PEND_DEPTH) - SP_W'(count) + SP_W'(drain_cnt);
        fr_ready   = (space >= SP_W'(2));
        drain_done = buf_empty & (fr_valid == 2'b00) & (push_fl_RAT == 2'd0);
    end

    // Store newer frees only while older ones are still waiting; no reset needed for data.
    always_ff @(posedge clk) begin
        if (!buf_empty) begin
            if (enq_cnt != 2'd0) begin
                pend_mem[wr_ptr] <= enq0;
            end
            if (enq_cnt == 2'd2) begin
                pend_mem[wr_ptr + PTR_W'(1)] <= fr_pr1;
            end
        end
    end

    // Advance FIFO pointers and occupancy; an empty buffer lets frees bypass it entirely.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            rd_ptr <= '0;
            wr_ptr <= '0;
            count  <= '0;
        end else if (!buf_empty) begin
            rd_ptr <= rd_ptr + PTR_W'(drain_cnt);
            wr_ptr <= wr_ptr + PTR_W'(enq_cnt);
            count  <= count - CNT_W'(drain_cnt) + CNT_W'(enq_cnt);
        end
    end

    // Register the freelist push: buffered entries first, otherwise this cycle's frees.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            push_fl_RAT       <= 2'd0;
            push_data_fl_RAT1 <= '0;
            push_data_fl_RAT2 <= '0;
        end else if (buf_empty) begin
            push_fl_RAT       <= enq_cnt;
            push_data_fl_RAT1 <= (enq_cnt != 2'd0) ? enq0 : '0;
            push_data_fl_RAT2 <= (enq_cnt == 2'd2) ? fr_pr1 : '0;
        end else begin
            push_fl_RAT       <= drain_cnt;
            push_data_fl_RAT1 <= head0;
            push_data_fl_RAT2 <= (drain_cnt == 2'd2) ? head1 : '0;
        end
    end

    // FSM state register.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state <= RUN;
        end else begin
            state <= state_nxt;
        end
    end

    // FSM next state: flush enters DRAIN; leave only once nothing is left in flight.
    always_comb begin
        state_nxt = state;
        case (state)
            RUN: begin
                if (flush) begin
                    state_nxt = DRAIN;
                end
            end
            DRAIN: begin
                if (!flush && drain_done) begin
                    state_nxt = RUN;
                end
            end
            default: state_nxt = RUN;
        endcase
    end

    // FSM outputs.
    always_comb begin
        run_state  = (state == RUN);
        drain_busy = (state == DRAIN);
    end

`ifdef FL_STALL_CNT_EN
    // Count cycles where a rename group is presented but the freelist cannot cover it.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            perf_stall_cnt <= 16'd0;
        end else if (run_state && (ren_valid != 2'b00) && !avail && (perf_stall_cnt != 16'hFFFF)) begin
            perf_stall_cnt <= perf_stall_cnt + 16'd1;
        end
    end
`endif

    // Commit must never offer frees when the buffer cannot take two more.
    fr_accept_legal: assert property (@(posedge clk) disable iff (!reset)
        (fr_valid != 2'b00) |-> fr_ready);

endmodule
